cp0_ctrl: RTL and testbench
===========================

# cp0_ctrl

Parametrised coprocessor-0 block for the MIPS core: holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId. It commits precise exceptions and ERET, synchronises N_HINT hardware interrupt lines, and runs a Count/Compare timer. It produces the masked interrupt vector and a single interrupt request for the exception unit. It sits beside the integer register file and is read/written by MFC0/MTC0 in the writeback path.

## Interface
- N_HINT, 6, number of hardware interrupt inputs (1..6), mapped to Cause.IP[2+N_HINT-1:2]; unused IP bits read 0
- PRID, 32'h0000_4220, constant value returned by PRId (reg 15)
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  5  MFC0 read register number
- rd_data  out  32  combinational read data for rd_addr
- wr_en  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register number
- wr_data  in  32  MTC0 data
- exc_we  in  1  exception commit strobe
- exc_bd  in  1  faulting instruction in branch delay slot
- exc_code  in  5  ExcCode to record
- exc_epc  in  32  EPC to record
- exc_bva_we  in  1  also load BadVAddr (address exceptions only)
- exc_bva  in  32  faulting virtual address
- eret  in  1  ERET commit strobe
- hard_intr  in  N_HINT  level-sensitive external interrupt lines
- intr_vect  out  8  Cause.IP & Status.IM, forced 0 when Status.IE=0 or Status.EXL=1
- intr_req  out  1  OR-reduction of intr_vect
- er_epc  out  32  current EPC, for ERET target

## Operation
- Reset (rst=0, asynchronous): BadVAddr, Count, Compare, Cause and EPC = 0; Status = STATUS_RST; timer phase = 0; TI = 0. All outputs derive from registers: rd_data reads the reset values, intr_vect=0, intr_req=0, er_epc=0.
- Writable fields via MTC0:
  - Status: IM[15:8], EXL[1], IE[0]; other bits hold.
  - Cause: IP[9:8] (software interrupts) only.
  - EPC: all bits. Count: all bits. Compare: all bits; also clears TI.
  - BadVAddr, PRId and unimplemented numbers: writes ignored.
- Reads: unimplemented registers return 0. Cause returns BD[31], TI[30], IP[15:8], ExcCode[6:2]; all other bits read 0.
- Exception commit (exc_we=1):
  - Cause.BD<=exc_bd, Cause.ExcCode<=exc_code, EPC<=exc_epc, Status.EXL<=1.
  - BadVAddr<=exc_bva only if exc_bva_we.
  - Count keeps running.
- ERET (eret=1, exc_we=0): Status.EXL<=0; no other field changes.
- Update priority: exc_we > eret > wr_en. The losing wr_en is dropped entirely, even for an unrelated register.
- Hardware lines are registered once into Cause.IP[2+i]; the IP bits track the lines level-wise and cannot be written.
- Timer: a 1-bit phase toggles every cycle, and Count increments on cycles where phase=1 (every 2nd clock). If the incremented value equals Compare, TI<=1. TI stays set until a Compare write.
- With the timer, IP7 = registered hard_intr[5] | TI. With N_HINT<6, IP7 = TI.
- Count arithmetic is 32-bit modulo: 0xFFFF_FFFF increments to 0x0000_0000, and a match at 0 is valid.
- MTC0 to Count in the same cycle as an increment: the written value wins, and there is no compare check that cycle. The phase is not reset.

## Timing
- rd_data: zero latency, combinational from current registers. A read of a register being written in the same cycle returns the old value; there is no bypass.
- All writes, commits and ERET take effect at the next rising edge.
- hard_intr -> intr_vect/intr_req: 1 cycle (one register stage, combinational mask).
- Count match -> intr_req: TI is set at the edge where Count becomes equal to Compare, and intr_req is high the same cycle (if IM7, IE set and EXL clear).
- Exception commit -> intr_req=0: next cycle, because EXL masks it.

## Configuration
- CP0_TIMER_EN defined: Count (9), Compare (11), phase and TI are implemented as above.
- CP0_TIMER_EN undefined:
  - Count and Compare read 0 and ignore writes; TI is constant 0.
  - IP7 = registered hard_intr[5] (0 if N_HINT<6).
  - No timer flops are synthesised.

## Test plan
- Reset then release -> Status reads 0x0040_0000, Cause, EPC and Count read 0, intr_req=0.
- Write Status=0x0000_0401, then pulse hard_intr[0]=1 -> one cycle later intr_vect=0x04, intr_req=1; drop hard_intr -> intr_req=0 one cycle later.
- Timer match (CP0_TIMER_EN):
  - Write Compare=10, Count=0, Status=0x0000_8001 -> after 20 cycles Count=10, Cause.TI=1, intr_req=1.
  - Then write Compare=100 -> TI=0 next cycle.
- exc_we with bd=1, code=0x04, epc=0x8000_0100, bva_we=1, bva=0x1234_5677, plus a simultaneous MTC0 to EPC:
  - Cause=0x8000_0010, EPC=0x8000_0100, BadVAddr=0x1234_5677, Status.EXL=1; the MTC0 is dropped.
  - Following eret -> EXL=0.
- Count wrap: write Compare=0, Count=0xFFFF_FFFF -> within 2 cycles Count=0, TI=1.
- Assert rst mid-operation with TI=1, EXL=1 -> all registers return to reset values immediately without a clock edge; intr_req=0.

Source files
------------

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cp0_ctrl
// Purpose  : MIPS coprocessor-0 register block. Holds BadVAddr (8), Count (9),
//            Compare (11), Status (12), Cause (13), EPC (14) and PRId (15).
//            Commits precise exceptions and ERET, registers the hardware
//            interrupt lines, runs the optional Count/Compare timer and
//            produces the masked interrupt vector and request.
// Build    : define CP0_TIMER_EN to implement Count/Compare, the timer phase
//            and Cause.TI. Without it Count/Compare read 0 and TI is 0.
// Ports    : clk, rst (async, active low)
//            rd_addr/rd_data            - MFC0 combinational read
//            wr_en/wr_addr/wr_data      - MTC0 write
//            exc_we/exc_bd/exc_code/exc_epc/exc_bva_we/exc_bva - exception
//            eret                       - ERET commit
//            hard_intr[N_HINT]          - level-sensitive interrupt lines
//            intr_vect/intr_req         - masked interrupts to exception unit
//            er_epc                     - current EPC (ERET target)
// Revision : 1.0 - initial release
// ============================================================================
module cp0_ctrl #(
   parameter int          N_HINT     = 6,
   parameter logic [31:0] PRID       = 32'h0000_4220,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        rd_addr,
   output logic [31:0]       rd_data,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              exc_we,
   input  logic              exc_bd,
   input  logic [4:0]        exc_code,
   input  logic [31:0]       exc_epc,
   input  logic              exc_bva_we,
   input  logic [31:0]       exc_bva,
   input  logic              eret,
   input  logic [N_HINT-1:0] hard_intr,
   output logic [7:0]        intr_vect,
   output logic              intr_req,
   output logic [31:0]       er_epc
);

   localparam logic [4:0] c_BADVADDR = 5'd8;
   localparam logic [4:0] c_COUNT    = 5'd9;
   localparam logic [4:0] c_COMPARE  = 5'd11;
   localparam logic [4:0] c_STATUS   = 5'd12;
   localparam logic [4:0] c_CAUSE    = 5'd13;
   localparam logic [4:0] c_EPC      = 5'd14;
   localparam logic [4:0] c_PRID     = 5'd15;

   logic [N_HINT-1:0] r_hw;
   logic [31:0]       r_badvaddr;
   logic [31:0]       r_status;
   logic [31:0]       r_epc;
   logic              r_bd;
   logic [4:0]        r_exc_code;
   logic [1:0]        r_sw;

   logic              w_ti;
   logic [31:0]       w_count;
   logic [31:0]       w_compare;
   logic [7:0]        w_ip;
   logic              w_wr;

   // An exception or ERET in the same cycle swallows the MTC0 completely.
   assign w_wr = wr_en & ~exc_we & ~eret;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hw       <= '0;
         r_badvaddr <= '0;
         r_status   <= STATUS_RST;
         r_epc      <= '0;
         r_bd       <= 1'b0;
         r_exc_code <= '0;
         r_sw       <= '0;
      end else begin
         r_hw <= hard_intr;
         if (exc_we) begin
            r_bd       <= exc_bd;
            r_exc_code <= exc_code;
            r_epc      <= exc_epc;
            r_status[1] <= 1'b1;
            if (exc_bva_we) begin
               r_badvaddr <= exc_bva;
            end
         end else if (eret) begin
            r_status[1] <= 1'b0;
         end else if (w_wr) begin
            case (wr_addr)
               c_STATUS: begin
                  r_status[15:8] <= wr_data[15:8];
                  r_status[1:0]  <= wr_data[1:0];
               end
               c_CAUSE:  r_sw  <= wr_data[9:8];
               c_EPC:    r_epc <= wr_data;
               default: ;
            endcase
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_phase;
   logic        r_ti;
   logic [31:0] w_cnt_inc;

   assign w_cnt_inc = r_count + 32'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count   <= '0;
         r_compare <= '0;
         r_phase   <= 1'b0;
         r_ti      <= 1'b0;
      end else begin
         r_phase <= ~r_phase;
         // A software write to Count overrides the increment and skips the
         // compare check for that cycle; the phase keeps running.
         if (w_wr && wr_addr == c_COUNT) begin
            r_count <= wr_data;
         end else if (r_phase) begin
            r_count <= w_cnt_inc;
            if (w_cnt_inc == r_compare) begin
               r_ti <= 1'b1;
            end
         end
         // Placed last so a Compare write acknowledges the timer even if a
         // match against the old Compare happens in the same cycle.
         if (w_wr && wr_addr == c_COMPARE) begin
            r_compare <= wr_data;
            r_ti      <= 1'b0;
         end
      end
   end

   assign w_ti      = r_ti;
   assign w_count   = r_count;
   assign w_compare = r_compare;
`else
   assign w_ti      = 1'b0;
   assign w_count   = '0;
   assign w_compare = '0;
`endif

   // Cause.IP: [1:0] software, [6:2] hardware lines 0..4, [7] line 5 | TI.
   assign w_ip[1:0] = r_sw;

   generate
      for (genvar i = 0; i < 5; i++) begin : g_ip
         if (i < N_HINT) begin : g_used
            assign w_ip[2+i] = r_hw[i];
         end else begin : g_unused
            assign w_ip[2+i] = 1'b0;
         end
      end
      if (N_HINT == 6) begin : g_ip7_hw
         assign w_ip[7] = r_hw[5] | w_ti;
      end else begin : g_ip7_ti
         assign w_ip[7] = w_ti;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      case (rd_addr)
         c_BADVADDR: rd_data = r_badvaddr;
         c_COUNT:    rd_data = w_count;
         c_COMPARE:  rd_data = w_compare;
         c_STATUS:   rd_data = r_status;
         c_CAUSE:    rd_data = {r_bd, w_ti, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};
         c_EPC:      rd_data = r_epc;
         c_PRID:     rd_data = PRID;
         default:    rd_data = '0;
      endcase
   end

   // IE must be set and EXL clear for any interrupt to reach the core.
   assign intr_vect = (r_status[0] && !r_status[1]) ? (w_ip & r_status[15:8]) : 8'h00;
   assign intr_req  = |intr_vect;
   assign er_epc    = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_ctrl
// Purpose  : Directed self-checking bench for cp0_ctrl (default parameters).
//            Timer checks are built when CP0_TIMER_EN is defined; otherwise
//            the bench checks that Count/Compare read 0 and ignore writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        exc_we;
   logic        exc_bd;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;
   logic        exc_bva_we;
   logic [31:0] exc_bva;
   logic        eret;
   logic [5:0]  hard_intr;
   logic [7:0]  intr_vect;
   logic        intr_req;
   logic [31:0] er_epc;

   int checks = 0;
   int errors = 0;

   cp0_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .exc_we     (exc_we),
      .exc_bd     (exc_bd),
      .exc_code   (exc_code),
      .exc_epc    (exc_epc),
      .exc_bva_we (exc_bva_we),
      .exc_bva    (exc_bva),
      .eret       (eret),
      .hard_intr  (hard_intr),
      .intr_vect  (intr_vect),
      .intr_req   (intr_req),
      .er_epc     (er_epc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      rd_addr = addr;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      exc_we = 1'b0; exc_bd = 1'b0; exc_code = '0; exc_epc = '0;
      exc_bva_we = 1'b0; exc_bva = '0; eret = 1'b0; hard_intr = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Reset state
      rd_chk("rst_status", 5'd12, 32'h0040_0000);
      rd_chk("rst_cause",  5'd13, 32'h0);
      rd_chk("rst_epc",    5'd14, 32'h0);
      rd_chk("rst_count",  5'd9,  32'h0);
      rd_chk("rst_bva",    5'd8,  32'h0);
      rd_chk("rst_prid",   5'd15, 32'h0000_4220);
      check("rst_intr_req", {31'b0, intr_req}, 32'h0);
      check("rst_er_epc", er_epc, 32'h0);

      // Status write: only IM/EXL/IE change, BEV holds
      mtc0(5'd12, 32'h0000_0401);
      rd_chk("status_wr", 5'd12, 32'h0040_0401);

      // Hardware line 0 -> IP2, one register stage
      hard_intr = 6'h01;
      tick();
      check("hw0_vect", {24'b0, intr_vect}, 32'h04);
      check("hw0_req", {31'b0, intr_req}, 32'h1);
      rd_chk("hw0_cause", 5'd13, 32'h0000_0400);
      hard_intr = 6'h00;
      tick();
      check("hw0_drop_req", {31'b0, intr_req}, 32'h0);

      // Software interrupts: only IP[9:8] writable
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd_chk("sw_cause", 5'd13, 32'h0000_0300);
      check("sw_masked", {24'b0, intr_vect}, 32'h00);
      mtc0(5'd12, 32'h0000_0101);
      check("sw_vect", {24'b0, intr_vect}, 32'h01);
      mtc0(5'd13, 32'h0);
      check("sw_clear_req", {31'b0, intr_req}, 32'h0);

      // Line 5 -> IP7, then masked by IE=0
      mtc0(5'd12, 32'h0000_8001);
      hard_intr = 6'h20;
      tick();
      check("hw5_vect", {24'b0, intr_vect}, 32'h80);
      mtc0(5'd12, 32'h0000_8000);
      check("ie_off_vect", {24'b0, intr_vect}, 32'h00);
      hard_intr = 6'h00;

      // Ignored writes and unimplemented reads
      mtc0(5'd8, 32'hDEAD_BEEF);
      rd_chk("bva_wr_ign", 5'd8, 32'h0);
      mtc0(5'd15, 32'hDEAD_BEEF);
      rd_chk("prid_wr_ign", 5'd15, 32'h0000_4220);
      mtc0(5'd3, 32'hDEAD_BEEF);
      rd_chk("unimpl_rd", 5'd3, 32'h0);

      // No read bypass: old EPC visible during the write cycle
      tick();
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hA5A5_0004;
      rd_chk("epc_nobypass", 5'd14, 32'h0);
      tick();
      wr_en = 1'b0;
      rd_chk("epc_wr", 5'd14, 32'hA5A5_0004);
      check("er_epc_wr", er_epc, 32'hA5A5_0004);

      // Exception with a simultaneous MTC0 to EPC (dropped)
      mtc0(5'd12, 32'h0000_0401);
      hard_intr = 6'h01;
      tick();
      check("pre_exc_req", {31'b0, intr_req}, 32'h1);
      exc_we = 1'b1; exc_bd = 1'b1; exc_code = 5'h04; exc_epc = 32'h8000_0100;
      exc_bva_we = 1'b1; exc_bva = 32'h1234_5677;
      wr_en = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEEF;
      tick();
      exc_we = 1'b0; exc_bva_we = 1'b0; wr_en = 1'b0;
      check("exc_req_masked", {31'b0, intr_req}, 32'h0);
      rd_chk("exc_cause",  5'd13, 32'h8000_0410);
      rd_chk("exc_epc",    5'd14, 32'h8000_0100);
      rd_chk("exc_bva",    5'd8,  32'h1234_5677);
      rd_chk("exc_status", 5'd12, 32'h0040_0403);

      // ERET with a losing MTC0 to Status
      tick();
      eret = 1'b1; wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0;
      tick();
      eret = 1'b0; wr_en = 1'b0;
      rd_chk("eret_status", 5'd12, 32'h0040_0401);
      check("eret_req", {31'b0, intr_req}, 32'h1);
      check("eret_er_epc", er_epc, 32'h8000_0100);

      // Exception beats ERET; BadVAddr holds without exc_bva_we
      tick();
      exc_we = 1'b1; eret = 1'b1; exc_bd = 1'b0; exc_code = 5'h0C;
      exc_epc = 32'h0040_0020; exc_bva = 32'hFFFF_0000;
      tick();
      exc_we = 1'b0; eret = 1'b0;
      rd_chk("exc2_cause",  5'd13, 32'h0000_0430);
      rd_chk("exc2_bva",    5'd8,  32'h1234_5677);
      rd_chk("exc2_status", 5'd12, 32'h0040_0403);
      tick();
      eret = 1'b1;
      hard_intr = 6'h00;
      tick();
      eret = 1'b0;

`ifdef CP0_TIMER_EN
      begin
         logic found;
         // Compare match
         mtc0(5'd11, 32'd10);
         mtc0(5'd9, 32'd0);
         mtc0(5'd12, 32'h0000_8001);
         rd_addr = 5'd13;
         found = 1'b0;
         for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_data[30]) begin
               found = 1'b1;
               break;
            end
         end
         check("ti_seen", {31'b0, found}, 32'h1);
         rd_chk("ti_count", 5'd9, 32'd10);
         check("ti_req", {31'b0, intr_req}, 32'h1);
         check("ti_vect", {24'b0, intr_vect}, 32'h80);
         mtc0(5'd11, 32'd100);
         rd_addr = 5'd13; #1;
         check("ti_clear", {31'b0, rd_data[30]}, 32'h0);
         check("ti_clear_req", {31'b0, intr_req}, 32'h0);

         // Count wrap with match at zero
         mtc0(5'd11, 32'd0);
         mtc0(5'd9, 32'hFFFF_FFFF);
         rd_addr = 5'd13;
         found = 1'b0;
         for (int i = 0; i < 4; i++) begin
            #1;
            if (rd_data[30]) begin
               found = 1'b1;
               break;
            end
            tick();
         end
         check("wrap_ti", {31'b0, found}, 32'h1);
         rd_chk("wrap_count", 5'd9, 32'h0);
      end
`else
      mtc0(5'd9, 32'd5);
      rd_chk("notimer_count", 5'd9, 32'h0);
      mtc0(5'd11, 32'd5);
      rd_chk("notimer_compare", 5'd11, 32'h0);
      rd_chk("notimer_cause", 5'd13, 32'h0000_0030);
`endif

      // Asynchronous reset mid-operation with EXL set
      tick();
      exc_we = 1'b1; exc_code = 5'h01; exc_epc = 32'h1111_2222;
      tick();
      exc_we = 1'b0;
      rd_chk("pre_rst_epc", 5'd14, 32'h1111_2222);
      tick();
      rst = 1'b0;
      rd_chk("arst_status", 5'd12, 32'h0040_0000);
      rd_chk("arst_cause",  5'd13, 32'h0);
      rd_chk("arst_epc",    5'd14, 32'h0);
      rd_chk("arst_bva",    5'd8,  32'h0);
      rd_chk("arst_count",  5'd9,  32'h0);
      check("arst_req", {31'b0, intr_req}, 32'h0);
      check("arst_er_epc", er_epc, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
